// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// alu_seq: sequential ALU with valid/ready request and response handshakes.
// Single-cycle ops (arithmetic, logic, shifts, illegal) finish on the accept
// edge. Unsigned multiply runs WIDTH shift-add iterations and then reports.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   a_i, b_i, cin_i, sel_i  operands, carry-in, opcode (captured on accept)
//   valid_i / ready_o       request handshake (ready_o only in IDLE)
//   f_o                     registered result
//   cout_o, zero_o, neg_o,
//   ovf_o, err_o            registered flags
//   valid_o / ready_i       response handshake (valid_o only in DONE)
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [3:0]       sel_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] f_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o,
  output logic             err_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [SHW:0] MUL_ITERS = WIDTH[SHW:0];
  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   f_q;
  logic               cout_q, zero_q, neg_q, ovf_q, err_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW:0]       cnt_q;

  logic [WIDTH-1:0]   opX;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     shAmt;
  logic [2*WIDTH-1:0] rotTmp;
  logic [WIDTH-1:0]   aluF_d;
  logic               aluCout_d, aluOvf_d, aluErr_d;
  logic [2*WIDTH-1:0] accStep_d;

  // Single-cycle datapath, evaluated straight from the request inputs so the
  // result can be registered on the accept edge itself.
  always_comb begin
    shAmt = b_i[SHW-1:0];
    case (sel_i[1:0])
      2'b00:   opX = '0;
      2'b01:   opX = b_i;
      2'b10:   opX = ~b_i;
      default: opX = '1;
    endcase
    sum = {1'b0, a_i} + {1'b0, opX} + {{WIDTH{1'b0}}, cin_i};
    // Rotate by shifting a doubled copy; the upper half holds the rotation,
    // which also makes n = 0 return A without a special case.
    rotTmp = {a_i, a_i} << shAmt;

    aluF_d    = '0;
    aluCout_d = 1'b0;
    aluOvf_d  = 1'b0;
    aluErr_d  = 1'b0;
    case (sel_i)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        aluF_d    = sum[WIDTH-1:0];
        aluCout_d = sum[WIDTH];
        // Signed overflow: both addends share a sign the sum does not.
        aluOvf_d  = (a_i[WIDTH-1] == opX[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'b0100: aluF_d = a_i & b_i;
      4'b0101: aluF_d = a_i | b_i;
      4'b0110: aluF_d = a_i ^ b_i;
      4'b0111: aluF_d = ~a_i;
      4'b1000: begin
        aluF_d    = a_i >> 1;
        aluCout_d = a_i[0];
      end
      4'b1100: begin
        aluF_d    = a_i << 1;
        aluCout_d = a_i[WIDTH-1];
      end
      4'b1001: aluF_d = a_i >> shAmt;
      4'b1101: aluF_d = a_i << shAmt;
      4'b1010: aluF_d = $signed(a_i) >>> shAmt;
      4'b1110: aluF_d = rotTmp[2*WIDTH-1:WIDTH];
      4'b1011: aluF_d = '0;
      default: aluErr_d = 1'b1;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set.
  always_comb begin
    accStep_d = acc_q;
    if (mplier_q[0]) begin
      accStep_d = acc_q + mcand_q;
    end
  end

  // Control FSM plus all registered outputs. Reset clears everything, so a
  // multiply in flight is simply dropped and produces no response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      f_q      <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (sel_i == OP_MUL) begin
              state_q  <= MUL;
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a_i};
              mplier_q <= b_i;
              cnt_q    <= '0;
            end else begin
              state_q <= DONE;
              f_q     <= aluF_d;
              cout_q  <= aluCout_d;
              zero_q  <= (aluF_d == '0);
              neg_q   <= aluF_d[WIDTH-1];
              ovf_q   <= aluOvf_d;
              err_q   <= aluErr_d;
            end
          end
        end
        MUL: begin
          // WIDTH iterations first, then one more edge to publish the product.
          if (cnt_q == MUL_ITERS) begin
            state_q <= DONE;
            f_q     <= acc_q[WIDTH-1:0];
            cout_q  <= |acc_q[2*WIDTH-1:WIDTH];
            zero_q  <= (acc_q[WIDTH-1:0] == '0);
            neg_q   <= acc_q[WIDTH-1];
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
          end else begin
            acc_q    <= accStep_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign f_o     = f_q;
  assign cout_o  = cout_q;
  assign zero_o  = zero_q;
  assign neg_o   = neg_q;
  assign ovf_o   = ovf_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// Self-checking bench for alu_seq at WIDTH = 32: directed vector table,
// randomized ops against a plain-arithmetic reference model, and hand-written
// backpressure and reset-during-multiply sequences.
module tb_alu_seq;

  localparam int W = 32;
  localparam logic [31:0] OPA = 32'hA5A5F0F0;
  localparam logic [31:0] OPB = 32'h0F0F5A5A;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          cin_i = 1'b0;
  logic [3:0]    sel_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  f_o;
  logic          cout_o, zero_o, neg_o, ovf_o, err_o;
  logic          valid_o;
  logic          ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] f;
    logic        cout, ovf, err, zero, neg;
    int          lat;
  } result_t;

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] f;
    logic        cout, ovf, err;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .sel_i   (sel_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .f_o     (f_o),
    .cout_o  (cout_o),
    .zero_o  (zero_o),
    .neg_o   (neg_o),
    .ovf_o   (ovf_o),
    .err_o   (err_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Latency is counted in edges after the accept edge: single-cycle ops are
  // already reporting right after accept, multiply needs WIDTH+1 more edges.
  function automatic result_t finishExp(input logic [31:0] f, input logic cout, ovf, err,
                                        input logic [3:0] sel);
    result_t r;
    r.f    = f;
    r.cout = cout;
    r.ovf  = ovf;
    r.err  = err;
    r.zero = (f == 32'd0);
    r.neg  = f[31];
    r.lat  = (sel == 4'b1011) ? W + 1 : 0;
    return r;
  endfunction

  // Reference model using 64-bit integer arithmetic.
  function automatic result_t refModel(input logic [31:0] a, b, input logic cin,
                                       input logic [3:0] sel);
    longint unsigned ua, ub, x, wide;
    longint          sa;
    int              n;
    logic [31:0]     f;
    logic            cout, ovf, err;
    ua = 64'(a);
    ub = 64'(b);
    n = int'(b[4:0]);
    f = '0; cout = 1'b0; ovf = 1'b0; err = 1'b0;
    x = 0; wide = 0; sa = 0;
    case (sel)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        case (sel)
          4'd0:    x = 0;
          4'd1:    x = ub;
          4'd2:    x = 64'hFFFF_FFFF - ub;
          default: x = 64'hFFFF_FFFF;
        endcase
        wide = ua + x + 64'(cin);
        f    = wide[31:0];
        cout = wide[32];
        sa   = longint'($signed(a)) + longint'($signed(x[31:0])) + longint'(cin);
        ovf  = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
      end
      4'd4:  f = a & b;
      4'd5:  f = a | b;
      4'd6:  f = a ^ b;
      4'd7:  f = ~a;
      4'd8:  begin f = 32'(ua / 2); cout = (ua % 2) == 1; end
      4'd12: begin wide = ua * 2; f = wide[31:0]; cout = wide[32]; end
      4'd9:  f = 32'(ua >> n);
      4'd13: begin wide = ua << n; f = wide[31:0]; end
      4'd10: begin sa = longint'($signed(a)) >>> n; f = 32'(sa); end
      4'd14: begin wide = (ua << n) | (ua >> (32 - n)); f = wide[31:0]; end
      4'd11: begin wide = ua * ub; f = wide[31:0]; cout = (wide[63:32] != 0); end
      default: err = 1'b1;
    endcase
    return finishExp(f, cout, ovf, err, sel);
  endfunction

  task automatic checkResult(input string tag, input result_t exp);
    checkOutput({tag, " f"}, 64'(f_o), 64'(exp.f));
    checkOutput({tag, " flags{cout,zero,neg,ovf,err}"},
                64'({cout_o, zero_o, neg_o, ovf_o, err_o}),
                64'({exp.cout, exp.zero, exp.neg, exp.ovf, exp.err}));
  endtask

  // One full transaction: request, bounded wait for the response (with
  // ignored valid_i pulses and scrambled inputs meanwhile), optional
  // backpressure, then the response handshake with valid_i held high to show
  // no request is taken on that same edge.
  task automatic applyStimulus(input string tag, input logic [31:0] a, b, input logic cin,
                               input logic [3:0] sel, input result_t exp, input int hold);
    int edges;
    @(negedge clk_i);
    a_i = a; b_i = b; cin_i = cin; sel_i = sel; valid_i = 1'b1; ready_i = 1'b0;
    checkOutput({tag, " ready before accept"}, 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    a_i = $urandom(); b_i = $urandom(); cin_i = 1'($urandom()); sel_i = 4'($urandom());
    edges = 0;
    while (!valid_o && edges < 100) begin
      valid_i = 1'($urandom());
      @(posedge clk_i); #1;
      edges++;
      if (!valid_o) checkOutput({tag, " ready while busy"}, 64'(ready_o), 64'd0);
    end
    valid_i = 1'b0;
    checkOutput({tag, " latency"}, 64'(edges), 64'(exp.lat));
    checkResult(tag, exp);
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'($urandom());
      @(posedge clk_i); #1;
      checkOutput({tag, " valid held"}, 64'(valid_o), 64'd1);
      checkResult({tag, " held"}, exp);
    end
    @(negedge clk_i);
    ready_i = 1'b1; valid_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput({tag, " release {valid,ready}"}, 64'({valid_o, ready_o}), 64'd1);
    ready_i = 1'b0; valid_i = 1'b0;
  endtask

  initial begin
    result_t e;
    int seen;

    vecs.push_back('{"add",      4'b0001, OPA, OPB, 1'b0, 32'hB4B54B4A, 1'b0, 1'b0, 1'b0, 5});
    vecs.push_back('{"sub",      4'b0010, OPA, OPB, 1'b1, 32'h96969696, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{"dec",      4'b0011, OPA, OPB, 1'b1, OPA,          1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{"addovf",   4'b0001, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{"rotl4",    4'b1110, OPA, 32'd4, 1'b0, 32'h5A5F0F0A, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{"rotl0",    4'b1110, OPA, 32'd32, 1'b0, OPA,         1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{"sra4",     4'b1010, OPA, 32'd4, 1'b0, 32'hFA5A5F0F, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{"srl1",     4'b1000, OPA, OPB, 1'b0, 32'h52D2F878,   1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{"shl1",     4'b1100, OPA, OPB, 1'b0, 32'h4B4BE1E0,   1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{"mul16",    4'b1011, 32'h00010000, 32'h00010000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{"mulmax",   4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 0});
    vecs.push_back('{"mulsmall", 4'b1011, 32'd3, 32'd5, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0, 0});
    vecs.push_back('{"illegal",  4'b1111, OPA, OPB, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 5});

    // Asynchronous reset with no clock edge in between.
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("reset f", 64'(f_o), 64'd0);
    checkOutput("reset flags{cout,zero,neg,ovf,err}",
                64'({cout_o, zero_o, neg_o, ovf_o, err_o}), 64'b01000);
    checkOutput("reset {valid,ready}", 64'({valid_o, ready_o}), 64'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      e = finishExp(vecs[i].f, vecs[i].cout, vecs[i].ovf, vecs[i].err, vecs[i].sel);
      applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sel, e, vecs[i].hold);
    end

    $display("[TB] randomized ops");
    for (int i = 0; i < 120; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rs;
      logic        rc;
      ra = $urandom();
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      if (i % 17 == 0) ra = '0;
      rs = 4'($urandom_range(0, 15));
      rc = 1'($urandom());
      applyStimulus("random", ra, rb, rc, rs, refModel(ra, rb, rc, rs), $urandom_range(0, 3));
    end

    $display("[TB] reset during multiply");
    applyStimulus("pre-reset add", OPA, OPB, 1'b0, 4'b0001, refModel(OPA, OPB, 1'b0, 4'b0001), 0);
    @(negedge clk_i);
    a_i = 32'h00010000; b_i = 32'h00010000; sel_i = 4'b1011; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    checkOutput("midmul reset f", 64'(f_o), 64'd0);
    checkOutput("midmul reset flags{cout,zero,neg,ovf,err}",
                64'({cout_o, zero_o, neg_o, ovf_o, err_o}), 64'b01000);
    checkOutput("midmul reset {valid,ready}", 64'({valid_o, ready_o}), 64'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("after release {valid,ready}", 64'({valid_o, ready_o}), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen++;
    end
    checkOutput("no response after abort", 64'(seen), 64'd0);
    applyStimulus("post-reset add", OPA, OPB, 1'b0, 4'b0001,
                  finishExp(32'hB4B54B4A, 1'b0, 1'b0, 1'b0, 4'b0001), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
